// File: rtl/enqueue_agent_pkg.sv
// Shared constants, FSM state type and SUME dst_port decode for the enqueue agent.
package enqueue_agent_pkg;

  localparam int unsigned NUM_PORTS      = 5;
  localparam int unsigned DST_POS        = 24;
  localparam int unsigned PIFO_VALID_POS = 36;
  localparam int unsigned TUSER_W        = 128;

  typedef enum logic [0:0] {
    SOP,
    IN_PKT
  } state_e;

  // Even dst bits select MAC ports 0..3; any odd bit targets the DMA/CPU port.
  function automatic logic [NUM_PORTS-1:0] dst_to_mask(input logic [7:0] dst);
    return {dst[1] | dst[3] | dst[5] | dst[7], dst[6], dst[4], dst[2], dst[0]};
  endfunction

endpackage

// File: rtl/enqueue_agent_if.sv
// AXI-Stream side channel plus per-port buffer/PIFO control seen by the enqueue agent.
interface enqueue_agent_if;
  import enqueue_agent_pkg::*;

  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic [TUSER_W-1:0]   s_axis_tuser;
  logic                 s_axis_tlast;
  logic [NUM_PORTS-1:0] s_axis_buffer_almost_full;
  logic [NUM_PORTS-1:0] m_axis_ctl_pifo_in_en;
  logic [NUM_PORTS-1:0] m_axis_ctl_buffer_wr_en;

  modport slave (
    input  s_axis_tvalid,
    output s_axis_tready,
    input  s_axis_tuser,
    input  s_axis_tlast,
    input  s_axis_buffer_almost_full,
    output m_axis_ctl_pifo_in_en,
    output m_axis_ctl_buffer_wr_en
  );

  modport master (
    output s_axis_tvalid,
    input  s_axis_tready,
    output s_axis_tuser,
    output s_axis_tlast,
    output s_axis_buffer_almost_full,
    input  m_axis_ctl_pifo_in_en,
    input  m_axis_ctl_buffer_wr_en
  );

endinterface

// File: rtl/enqueue_agent.sv
// Admission control: decides per-packet destinations on the first beat, then drives
// per-beat buffer write enables and a single PIFO insert pulse per admitted packet.
module enqueue_agent
  import enqueue_agent_pkg::*;
(
  input  logic          axis_aclk,
  input  logic          axis_resetn,
  enqueue_agent_if.slave axis
);

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] admit_q, admit_d;
  logic [NUM_PORTS-1:0] wr_en_q, wr_en_d;
  logic [NUM_PORTS-1:0] pifo_q, pifo_d;
  logic [NUM_PORTS-1:0] dst_mask;
  logic [NUM_PORTS-1:0] admit_first;
  logic                 accept;
  logic                 sop;

  // No backpressure: ready simply tracks reset.
  assign axis.s_axis_tready = axis_resetn;
  assign accept             = axis.s_axis_tvalid & axis_resetn;
  assign sop                = (state_q == SOP);

  assign dst_mask    = dst_to_mask(axis.s_axis_tuser[DST_POS +: 8]);
  assign admit_first = dst_mask & ~axis.s_axis_buffer_almost_full;

  // Remaining tuser bits (including the reserved PIFO valid flag) are not consumed yet.
  logic unused_tuser;
  assign unused_tuser = ^{axis.s_axis_tuser[TUSER_W-1:DST_POS+8],
                          axis.s_axis_tuser[DST_POS-1:0],
                          axis.s_axis_tuser[PIFO_VALID_POS]};

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state_q <= SOP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        SOP:     if (!axis.s_axis_tlast) state_d = IN_PKT;
        IN_PKT:  if (axis.s_axis_tlast)  state_d = SOP;
        default: state_d = SOP;
      endcase
    end
  end

  always_comb begin
    admit_d = admit_q;
    wr_en_d = '0;
    pifo_d  = '0;
    if (accept) begin
      if (sop) begin
        admit_d = admit_first;
        wr_en_d = admit_first;
        pifo_d  = admit_first;
      end else begin
        wr_en_d = admit_q;
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      admit_q <= '0;
      wr_en_q <= '0;
      pifo_q  <= '0;
    end else begin
      admit_q <= admit_d;
      wr_en_q <= wr_en_d;
      pifo_q  <= pifo_d;
    end
  end

  assign axis.m_axis_ctl_buffer_wr_en = wr_en_q;
  assign axis.m_axis_ctl_pifo_in_en   = pifo_q;

endmodule

// File: tb/tb_enqueue_agent.sv
// Scoreboard bench for enqueue_agent: expected enables are queued per driven cycle and
// compared one cycle later against the registered outputs.
module tb_enqueue_agent;
  import enqueue_agent_pkg::*;

  typedef struct {
    logic [4:0] wr;
    logic [4:0] pifo;
  } exp_t;

  logic axis_aclk;
  logic axis_resetn;
  int   n_cmp;
  int   n_mis;
  exp_t sb_q[$];

  enqueue_agent_if bus ();

  enqueue_agent dut (
    .axis_aclk   (axis_aclk),
    .axis_resetn (axis_resetn),
    .axis        (bus.slave)
  );

  initial axis_aclk = 1'b0;
  always #5 axis_aclk = ~axis_aclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [127:0] rand_tuser();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, "_wr"},   {27'd0, bus.m_axis_ctl_buffer_wr_en}, {27'd0, e.wr});
      check_eq({tag, "_pifo"}, {27'd0, bus.m_axis_ctl_pifo_in_en},   {27'd0, e.pifo});
    end
  endtask

  task automatic drive_beat(input string tag, input logic [127:0] tuser, input logic last,
                            input logic [4:0] af, input logic [4:0] ew, input logic [4:0] ep);
    exp_t e;
    bus.s_axis_tvalid             = 1'b1;
    bus.s_axis_tuser              = tuser;
    bus.s_axis_tlast              = last;
    bus.s_axis_buffer_almost_full = af;
    e.wr   = ew;
    e.pifo = ep;
    sb_q.push_back(e);
    check_eq({tag, "_tready"}, {31'd0, bus.s_axis_tready}, 32'd1);
    @(posedge axis_aclk);
    #1;
    pop_compare(tag);
  endtask

  task automatic drive_idle(input string tag);
    exp_t e;
    bus.s_axis_tvalid             = 1'b0;
    bus.s_axis_tuser              = rand_tuser();
    bus.s_axis_tlast              = 1'($urandom);
    bus.s_axis_buffer_almost_full = 5'($urandom);
    e.wr   = '0;
    e.pifo = '0;
    sb_q.push_back(e);
    @(posedge axis_aclk);
    #1;
    pop_compare(tag);
  endtask

  // Later beats carry random tuser so only the first beat's dst field may matter.
  task automatic send_pkt(input string tag, input logic [7:0] dst, input int nbeats,
                          input logic [4:0] af0, input logic [4:0] af_rest,
                          input logic [4:0] exp_mask);
    logic [127:0] tu;
    for (int b = 0; b < nbeats; b++) begin
      tu = rand_tuser();
      if (b == 0) tu[31:24] = dst;
      drive_beat(tag, tu, (b == nbeats - 1), (b == 0) ? af0 : af_rest, exp_mask,
                 (b == 0) ? exp_mask : 5'b00000);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    axis_resetn                   = 1'b0;
    bus.s_axis_tvalid             = 1'b1;
    bus.s_axis_tuser              = rand_tuser();
    bus.s_axis_tlast              = 1'b0;
    bus.s_axis_buffer_almost_full = 5'b00000;

    repeat (20) @(posedge axis_aclk);
    #1;
    check_eq("rst_tready", {31'd0, bus.s_axis_tready}, 32'd0);
    check_eq("rst_wr",     {27'd0, bus.m_axis_ctl_buffer_wr_en}, 32'd0);
    check_eq("rst_pifo",   {27'd0, bus.m_axis_ctl_pifo_in_en},   32'd0);
    axis_resetn = 1'b1;
    #1;
    check_eq("rel_tready", {31'd0, bus.s_axis_tready}, 32'd1);

    send_pkt("two_beat", 8'h41, 2, 5'b00000, 5'b00000, 5'b01001);
    drive_idle("gap0");
    send_pkt("three_beat", 8'h54, 3, 5'b00000, 5'b00000, 5'b01110);
    send_pkt("drop_all", 8'h54, 3, 5'b01110, 5'b00000, 5'b00000);
    send_pkt("partial", 8'h54, 3, 5'b00110, 5'b00110, 5'b01000);
    send_pkt("af_late", 8'h54, 3, 5'b00000, 5'b01000, 5'b01110);
    drive_idle("gap1");

    // Single-beat packets back to back, including the odd-bit DMA/CPU mapping.
    send_pkt("b2b_p0", 8'h01, 1, 5'b00000, 5'b00000, 5'b00001);
    send_pkt("b2b_p4a", 8'h02, 1, 5'b00000, 5'b00000, 5'b10000);
    send_pkt("b2b_p4b", 8'h80, 1, 5'b00000, 5'b00000, 5'b10000);
    send_pkt("b2b_mix", 8'hA5, 1, 5'b00001, 5'b00000, 5'b10010);
    send_pkt("b2b_p2", 8'h10, 1, 5'b00000, 5'b00000, 5'b00100);

    // tvalid low mid-packet holds state and the latched mask.
    begin
      logic [127:0] tu;
      tu = rand_tuser();
      tu[31:24] = 8'h41;
      drive_beat("hold_b0", tu, 1'b0, 5'b00000, 5'b01001, 5'b01001);
      drive_idle("hold_gap");
      drive_beat("hold_b1", rand_tuser(), 1'b1, 5'b11111, 5'b01001, 5'b00000);
    end

    // Reset mid-packet: latched mask cleared and next beat treated as first beat.
    send_pkt("pre_rst", 8'h54, 1, 5'b00000, 5'b00000, 5'b01110);
    begin
      logic [127:0] tu;
      tu = rand_tuser();
      tu[31:24] = 8'h54;
      drive_beat("mid_b0", tu, 1'b0, 5'b00000, 5'b01110, 5'b01110);
    end
    axis_resetn       = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = 1'b0;
    repeat (2) @(posedge axis_aclk);
    #1;
    check_eq("mid_rst_tready", {31'd0, bus.s_axis_tready}, 32'd0);
    check_eq("mid_rst_wr",     {27'd0, bus.m_axis_ctl_buffer_wr_en}, 32'd0);
    check_eq("mid_rst_pifo",   {27'd0, bus.m_axis_ctl_pifo_in_en},   32'd0);
    axis_resetn = 1'b1;
    send_pkt("post_rst", 8'h01, 2, 5'b00000, 5'b00000, 5'b00001);
    drive_idle("tail");

    check_eq("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/enqueue_agent.md
# enqueue_agent

Admission-control stage between the packet pipeline output and the per-port packet buffers and PIFO schedulers. It watches each packet on the AXI-Stream side channel and reads the one-hot SUME destination field on the first beat. It masks out destinations whose buffer is almost full and holds that decision for the whole packet. It then drives per-port buffer write enables on every beat and a single PIFO insert pulse per packet; a packet with no admissible destination is consumed and dropped.

## Interface
Parameters:
- NUM_PORTS, 5: output ports (0–3 physical MAC, 4 DMA/CPU).
- DST_POS, 24: LSB of the 8-bit SUME dst_port field in tuser.
- PIFO_VALID_POS, 36: reserved tuser bit for PIFO info valid; ignored in v0.1.

Ports:
- axis_aclk  in  1  clock; all logic on the rising edge.
- axis_resetn  in  1  reset, synchronous, active-low.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat ready.
- s_axis_tuser  in  128  SUME metadata; only the first beat of a packet is sampled.
- s_axis_tlast  in  1  last beat of the packet.
- s_axis_buffer_almost_full  in  5  per-port buffer almost-full flags.
- m_axis_ctl_pifo_in_en  out  5  per-port PIFO insert pulse, one per admitted packet.
- m_axis_ctl_buffer_wr_en  out  5  per-port buffer write enable, one per admitted beat.

## Operation
- Beat accepted = s_axis_tvalid & s_axis_tready.
- Port map from tuser:
  - port i (i = 0..3) = tuser[DST_POS+2i], i.e. bits 24, 26, 28, 30.
  - port 4 = OR of tuser[25], [27], [29], [31].
- Two-state FSM:
  - SOP → IN_PKT on an accepted beat with tlast = 0.
  - IN_PKT → SOP on an accepted beat with tlast = 1.
  - An accepted beat in SOP with tlast = 1 is a single-beat packet; state stays SOP.
  - tvalid low in either state: hold state.
- First beat (state SOP): admit = dst_mask & ~s_axis_buffer_almost_full. Latch admit into a 5-bit register for the rest of the packet.
- Almost-full changes after the first beat are ignored until the next packet.
- buffer_wr_en: every accepted beat drives the admit mask (latched mask after the first beat).
- pifo_in_en: the admit mask for exactly one cycle, on the first beat only.
- admit = 0 (drop): beats are still accepted with tready high; both outputs stay 0 for the whole packet.
- s_axis_tready = 1 whenever out of reset. v0.1 has no backpressure.

## Timing
- Outputs are registered: enables appear one cycle after the accepted beat and are zero in every cycle with no accepted beat.
- Reset, including mid-packet: FSM → SOP, latched mask = 0, tready = 0, both enable outputs = 0. The first beat after reset is treated as SOP.
- Back-to-back packets (tlast beat followed immediately by the next first beat) are supported with no bubble.
- Throughput: 1 beat per cycle.

## Structure
- Shared package `enqueue_agent_pkg`:
  - NUM_PORTS, DST_POS, PIFO_VALID_POS.
  - FSM state enum {SOP, IN_PKT}.
  - dst-field-to-port-mask decode function.
- Single flat module. No sub-module is required; the decode is a package function.

## Test plan
- Reset: hold axis_resetn = 0 for 20 cycles → tready = 0, both enables = 00000. After release, tready = 1.
- Two-beat packet, dst bits 24 and 30, almost_full = 00000 → buffer_wr_en = 01001 for 2 cycles; pifo_in_en = 01001 for 1 cycle, aligned with the first write.
- Three-beat packet, dst bits 26, 28, 30, almost_full = 00000 → buffer_wr_en = 01110 for 3 cycles; pifo_in_en = 01110 once.
- Same packet with almost_full = 01110 → all beats accepted; both enables stay 00000 (drop).
- Same packet with almost_full = 00110 → buffer_wr_en = 01000 for 3 cycles; pifo_in_en = 01000 once.
- Almost_full rises to 01000 on beat 2 of an admitted 01110 packet → buffer_wr_en stays 01110 through tlast.
- Back-to-back single-beat packets → one pifo_in_en pulse each.
